// File: rtl/rf_rd_arb.sv
// rf_rd_arb
//   Round-robin arbiter sharing the single read port of a flop-output
//   register file among R read requesters. It also passes the write port
//   straight through to the register file.
//
//   Read path:
//     - A grant drives rf_ren/rf_ra.
//     - The registered rf_rdata comes back one cycle later as the response.
//     - rsp_id identifies the requester that the response belongs to.
//   Write path:
//     - Purely combinational pass-through.
//     - A read and a write to the same address in the same cycle return the
//       old data, because there is no forwarding.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/ready     per-requester read handshake (ready is one-hot or 0)
//   req_addr            per-requester read address
//   rsp_valid/ready     response handshake, full backpressure
//   rsp_id, rsp_data    requester index and read data of the response
//   wr_valid/addr/data  write request, always accepted
//   rf_*                register file port (ra/ren read, wa/wen/wdata write,
//                       rdata registered and held while ren=0)
module rf_rd_arb #(
  parameter  int W  = 32,
  parameter  int N  = 8,
  parameter  int R  = 4,
  localparam int AW = $clog2(N),
  localparam int IW = $clog2(R)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [R-1:0]          req_valid,
  input  logic [R-1:0][AW-1:0]  req_addr,
  output logic [R-1:0]          req_ready,
  output logic                  rsp_valid,
  output logic [IW-1:0]         rsp_id,
  output logic [W-1:0]          rsp_data,
  input  logic                  rsp_ready,
  input  logic                  wr_valid,
  input  logic [AW-1:0]         wr_addr,
  input  logic [W-1:0]          wr_data,
  output logic [AW-1:0]         rf_ra,
  output logic                  rf_ren,
  input  logic [W-1:0]          rf_rdata,
  output logic [AW-1:0]         rf_wa,
  output logic                  rf_wen,
  output logic [W-1:0]          rf_wdata
);

  logic          rsp_valid_q, rsp_valid_d;
  logic [IW-1:0] rsp_id_q,    rsp_id_d;
  logic [IW-1:0] ptr_q,       ptr_d;

  logic          can_issue;
  logic          gnt_any;
  logic [IW-1:0] gnt_idx;
  logic [IW:0]   scan_idx;

  // A stalled response blocks new grants, so that rf_rdata, which is held
  // while ren=0, keeps the stalled data stable. Reset also masks grants.
  assign can_issue = (!rsp_valid_q || rsp_ready) && !rst;

  // Rotating priority scan: offset 0 is ptr. The first valid requester wins.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < R; k++) begin
      scan_idx = {1'b0, ptr_q} + (IW+1)'(k);
      if (scan_idx >= (IW+1)'(R)) scan_idx = scan_idx - (IW+1)'(R);
      if (can_issue && !gnt_any && req_valid[scan_idx[IW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = scan_idx[IW-1:0];
      end
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    ptr_d       = ptr_q;
    if (gnt_any) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = gnt_idx;
      ptr_d       = (gnt_idx == IW'(R-1)) ? '0 : gnt_idx + IW'(1);
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      ptr_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      ptr_q       <= ptr_d;
    end
  end

  assign req_ready = gnt_any ? ({{(R-1){1'b0}}, 1'b1} << gnt_idx) : '0;
  assign rf_ren    = gnt_any;
  assign rf_ra     = gnt_any ? req_addr[gnt_idx] : '0;

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rf_rdata;

  assign rf_wen    = wr_valid;
  assign rf_wa     = wr_addr;
  assign rf_wdata  = wr_data;

endmodule

// File: doc/rf_rd_arb.md
Name: rf_rd_arb

Overview:
- Round-robin arbiter that shares the single read port of a register file among R requesters. The register file is instantiated with FLOP_OUT=1 and RD_N=WR_N=1.
- Requests use a valid/ready handshake. Responses come back one cycle after grant, tagged with the requester ID, under a single valid/ready response channel with full backpressure.
- The block also passes through the single write port, with defined read/write collision semantics.
- Sits between the pipeline's register-read clients and the rf instance.

Parameters:
- W, 32, data width; must match rf W.
- N, 8, rf entries; address width AW = $clog2(N).
- R, 4, number of read requesters (≥2); ID width IW = $clog2(R).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  R  per-requester read request valid
- req_addr  in  R×AW  per-requester read address
- req_ready  out  R  per-requester grant (one-hot or zero)
- rsp_valid  out  1  read response valid
- rsp_id  out  IW  requester index of response
- rsp_data  out  W  read data (wired from rf_rdata)
- rsp_ready  in  1  consumer accepts response
- wr_valid  in  1  write request
- wr_addr  in  AW  write address
- wr_data  in  W  write data
- rf_ra  out  AW  to rf ra
- rf_ren  out  1  to rf ren
- rf_rdata  in  W  from rf rdata (registered, holds when ren=0)
- rf_wa  out  AW  to rf wa
- rf_wen  out  1  to rf wen
- rf_wdata  out  W  to rf wdata

Behaviour:
- Reset (async, rst=1): rsp_valid=0, rsp_id=0, priority pointer ptr=0 (requester 0 highest).
  - req_ready is all zero while rst=1.
  - rsp_data is undefined while rsp_valid=0, since rf has no reset.
- Issue condition: can_issue = !rsp_valid | rsp_ready.
- Grant (combinational):
  - If can_issue and any req_valid, grant the first valid requester found scanning ptr, ptr+1, …, R-1, 0, …, ptr-1.
  - req_ready[g]=1 for that requester only; all others 0. No grant if !can_issue.
  - Handshake on a requester occurs when req_valid[i] & req_ready[i].
- rf read drive:
  - On grant: rf_ren=1 and rf_ra=req_addr[g].
  - Otherwise rf_ren=0 and rf_ra=0. rf then holds rf_rdata, which preserves a stalled response.
- Response:
  - Cycle after a grant: rsp_valid=1, rsp_id=g, rsp_data=rf_rdata = mem[addr] as it stood at the grant edge.
  - Latency is exactly 1 cycle, so back-to-back grants give one response per cycle.
- Pointer: on grant, ptr ← (g+1) mod R on the next edge; unchanged with no grant.
- Backpressure:
  - rsp_valid & !rsp_ready: rsp_valid, rsp_id and rsp_data stay stable, and no grant is issued.
  - Response accepted and new grant in the same cycle: rsp_valid stays 1 with the new ID/data.
  - Response accepted with no new grant: rsp_valid → 0.
- Writes are always accepted (no ready): rf_wen=wr_valid, rf_wa=wr_addr, rf_wdata=wr_data, combinational pass-through.
- Collision, read and write to the same address in the same cycle: the response returns the OLD data. There is no forwarding. The new value is visible to grants in later cycles.
- Requester drops req_valid without handshake: allowed; no state is retained for it.
- Reset mid-operation: a pending response is discarded (rsp_valid → 0 asynchronously) and ptr → 0. rf contents are unaffected.

Test Plan:
- Single read: write mem[3]=0xDEADBEEF, then requester 2 requests addr 3 → req_ready[2]=1 in cycle t; rsp_valid=1, rsp_id=2, rsp_data=0xDEADBEEF in t+1.
- Round robin fairness: all 4 requesters valid continuously, rsp_ready=1 → grant order 0,1,2,3,0,1… with one response per cycle; ptr wraps from 3 to 0.
- Backpressure: grant requester 1 (addr 5=0x55), rsp_ready=0 for 3 cycles while requester 0 is valid → rsp held (id=1, data=0x55); req_ready all zero. On the cycle rsp_ready=1, requester 0 is granted in that same cycle.
- Collision: mem[7]=0x11, then in the same cycle write mem[7]=0x22 and grant a read of addr 7 → rsp_data=0x11. A read the next cycle returns 0x22.
- Pointer skip: after a grant to requester 1 (ptr=2), only requesters 0 and 3 are valid → requester 3 is granted, then requester 0.
- Async reset: assert rst mid-stall while rsp_valid=1 → rsp_valid drops immediately, with no clock edge. After release, with all requesters valid, requester 0 is granted first.
